mdu_ctrl: RTL and testbench

//  Sequences the shared multiply/divide resources for EX and owns the HI/LO registers.

---
 rtl/mdu_ctrl_pkg.sv | 34 +++
 rtl/mdu_ctrl_if.sv | 48 ++++
 rtl/mdu_ctrl_hilo.sv | 25 ++
 rtl/mdu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared types for the multiply/divide sequencer: op codes, FSM states and
// small op-class helpers.
package mdu_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MFHI  = 3'd6,
        MDU_MFLO  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } mdu_state_t;

    function automatic logic is_mul(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-side, multiplier-side and divider-side signals of the MDU sequencer.
// div handshake: div_start_o stays high with stable operands until div_ready_i,
// which qualifies div_result_i for that single cycle; the cycle ready is seen ends the transfer.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic            op_valid;
    mdu_op_t         op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            ex_adv;
    logic            flush;

    logic            mul_signed_o;
    logic [XLEN-1:0] mul_ina_o;
    logic [XLEN-1:0] mul_inb_o;
    logic [63:0]     mul_result_i;

    logic            div_start_o;
    logic            div_signed_o;
    logic [XLEN-1:0] div_op1_o;
    logic [XLEN-1:0] div_op2_o;
    logic            div_annul_o;
    logic            div_ready_i;
    logic [63:0]     div_result_i;

    logic            stallreq_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;
    logic [XLEN-1:0] mf_data_o;

    modport slave (
        input  op_valid, op, src_a, src_b, ex_adv, flush,
        input  mul_result_i, div_ready_i, div_result_i,
        output mul_signed_o, mul_ina_o, mul_inb_o,
        output div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o,
        output stallreq_o, hi_o, lo_o, mf_data_o
    );

    modport master (
        output op_valid, op, src_a, src_b, ex_adv, flush,
        output mul_result_i, div_ready_i, div_result_i,
        input  mul_signed_o, mul_ina_o, mul_inb_o,
        input  div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o,
        input  stallreq_o, hi_o, lo_o, mf_data_o
    );

endinterface

// File: rtl/mdu_ctrl_hilo.sv
// HI/LO register pair with independent write enables.
module mdu_ctrl_hilo
    import mdu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] hi_wd,
    input  logic [XLEN-1:0] lo_wd,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_wd;
            if (lo_we) lo <= lo_wd;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Sequences the shared multiplier/divider for EX, owns HI/LO and raises
// stallreq until a multiply/divide result has been committed.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    mdu_ctrl_if.slave  bus,
    output mdu_state_t dbg_state
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    mdu_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] op_a_q, op_b_q;
    logic            sgn_q;
    logic            issue, latch_mul, latch_div;
    logic            hi_we, lo_we;
    logic [XLEN-1:0] hi_wd, lo_wd, hi_q, lo_q;

    // rst gates the issue path so every output is 0 while reset is held.
    assign issue     = bus.op_valid && !bus.flush && !rst && (state_q == ST_IDLE);
    assign latch_mul = issue && is_mul(bus.op);
    assign latch_div = issue && is_div(bus.op) && (bus.src_b != '0);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
            sgn_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (latch_mul || latch_div) begin
                op_a_q <= bus.src_a;
                op_b_q <= bus.src_b;
                sgn_q  <= (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
            end
            if (latch_mul)
                cnt_q <= CNT_W'(MUL_LAT - 1);
            else if ((state_q == ST_MUL_WAIT) && (cnt_q != '0))
                cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.op_valid && is_mul(bus.op))
                        state_d = ST_MUL_WAIT;
                    else if (bus.op_valid && is_div(bus.op))
                        state_d = (bus.src_b != '0) ? ST_DIV_WAIT : ST_DONE;
                end
                ST_MUL_WAIT: if (cnt_q == '0)      state_d = ST_DONE;
                ST_DIV_WAIT: if (bus.div_ready_i)  state_d = ST_DONE;
                ST_DONE:     if (bus.ex_adv)       state_d = ST_IDLE;
                default:                           state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mul_signed_o = 1'b0;
        bus.mul_ina_o    = '0;
        bus.mul_inb_o    = '0;
        bus.div_start_o  = 1'b0;
        bus.div_signed_o = 1'b0;
        bus.div_op1_o    = '0;
        bus.div_op2_o    = '0;
        bus.div_annul_o  = 1'b0;
        bus.stallreq_o   = 1'b0;
        hi_we            = 1'b0;
        lo_we            = 1'b0;
        hi_wd            = '0;
        lo_wd            = '0;
        case (state_q)
            ST_IDLE: begin
                if (issue && is_mul(bus.op)) begin
                    bus.mul_signed_o = (bus.op == MDU_MULT);
                    bus.mul_ina_o    = bus.src_a;
                    bus.mul_inb_o    = bus.src_b;
                    bus.stallreq_o   = 1'b1;
                end else if (issue && is_div(bus.op)) begin
                    bus.stallreq_o = 1'b1;
                    if (bus.src_b != '0) begin
                        bus.div_start_o  = 1'b1;
                        bus.div_signed_o = (bus.op == MDU_DIV);
                        bus.div_op1_o    = bus.src_a;
                        bus.div_op2_o    = bus.src_b;
                    end else begin
                        // Divide by zero never reaches the divider.
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        hi_wd = bus.src_a;
                        lo_wd = DIV0_LO;
                    end
                end else if (issue && (bus.op == MDU_MTHI)) begin
                    hi_we = 1'b1;
                    hi_wd = bus.src_a;
                end else if (issue && (bus.op == MDU_MTLO)) begin
                    lo_we = 1'b1;
                    lo_wd = bus.src_a;
                end
            end
            ST_MUL_WAIT: begin
                if (!bus.flush) begin
                    bus.mul_signed_o = sgn_q;
                    bus.mul_ina_o    = op_a_q;
                    bus.mul_inb_o    = op_b_q;
                    bus.stallreq_o   = 1'b1;
                    if (cnt_q == '0) begin
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        hi_wd = bus.mul_result_i[63:32];
                        lo_wd = bus.mul_result_i[31:0];
                    end
                end
            end
            ST_DIV_WAIT: begin
                if (bus.flush) begin
                    bus.div_annul_o = 1'b1;
                end else begin
                    bus.div_signed_o = sgn_q;
                    bus.div_op1_o    = op_a_q;
                    bus.div_op2_o    = op_b_q;
                    if (bus.div_ready_i) begin
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        hi_wd = bus.div_result_i[63:32];
                        lo_wd = bus.div_result_i[31:0];
                    end else begin
                        bus.div_start_o = 1'b1;
                        bus.stallreq_o  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.mf_data_o = '0;
        if (bus.op_valid && (bus.op == MDU_MFHI))      bus.mf_data_o = hi_q;
        else if (bus.op_valid && (bus.op == MDU_MFLO)) bus.mf_data_o = lo_q;
    end

    assign bus.hi_o = hi_q;
    assign bus.lo_o = lo_q;

    mdu_ctrl_hilo u_hilo (
        .clk   (clk),
        .rst   (rst),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi_wd (hi_wd),
        .lo_wd (lo_wd),
        .hi    (hi_q),
        .lo    (lo_q)
    );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: MT/MF vector table plus hand-written multiply, divide,
// divide-by-zero, flush and async-reset sequences.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  mdu_state_t dbg_state;
  int         n_total = 0;
  int         n_pass  = 0;

  always #5 clk = ~clk;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MUL_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // two-stage multiplier model: operands at cycle N, product visible in N+2
  logic [63:0] mul_ext_a, mul_ext_b, mul_s1, mul_s2;
  always_comb begin
    mul_ext_a = bus.mul_signed_o ? {{32{bus.mul_ina_o[31]}}, bus.mul_ina_o} : {32'd0, bus.mul_ina_o};
    mul_ext_b = bus.mul_signed_o ? {{32{bus.mul_inb_o[31]}}, bus.mul_inb_o} : {32'd0, bus.mul_inb_o};
  end
  always_ff @(posedge clk) begin
    mul_s1 <= mul_ext_a * mul_ext_b;
    mul_s2 <= mul_s1;
  end
  assign bus.mul_result_i = mul_s2;

  typedef struct {
    logic        op_valid;
    mdu_op_t     op;
    logic [31:0] src_a;
    logic        flush;
    logic        exp_stall;
    logic [31:0] exp_mf;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, MDU_MTHI, 32'd1234,      1'b0, 1'b0, 32'd0,          32'd0,          32'd0};
    vecs[1]  = '{1'b1, MDU_MFHI, 32'd0,         1'b0, 1'b0, 32'd1234,       32'd1234,       32'd0};
    vecs[2]  = '{1'b1, MDU_MTLO, 32'hCAFE_BABE, 1'b0, 1'b0, 32'd0,          32'd1234,       32'd0};
    vecs[3]  = '{1'b1, MDU_MFLO, 32'd0,         1'b0, 1'b0, 32'hCAFE_BABE,  32'd1234,       32'hCAFE_BABE};
    vecs[4]  = '{1'b0, MDU_MFHI, 32'd0,         1'b0, 1'b0, 32'd0,          32'd1234,       32'hCAFE_BABE};
    vecs[5]  = '{1'b1, MDU_MTHI, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0,          32'd1234,       32'hCAFE_BABE};
    vecs[6]  = '{1'b1, MDU_MTHI, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0,          32'hDEAD_BEEF,  32'hCAFE_BABE};
    vecs[7]  = '{1'b1, MDU_MFHI, 32'd0,         1'b0, 1'b0, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'hCAFE_BABE};
    vecs[8]  = '{1'b1, MDU_MTLO, 32'h1111_1111, 1'b1, 1'b0, 32'd0,          32'hDEAD_BEEF,  32'hCAFE_BABE};
    vecs[9]  = '{1'b1, MDU_MFLO, 32'd0,         1'b0, 1'b0, 32'hCAFE_BABE,  32'hDEAD_BEEF,  32'hCAFE_BABE};
    vecs[10] = '{1'b0, MDU_MTLO, 32'h2222_2222, 1'b0, 1'b0, 32'd0,          32'hDEAD_BEEF,  32'hCAFE_BABE};
    vecs[11] = '{1'b1, MDU_MFLO, 32'd0,         1'b0, 1'b0, 32'hCAFE_BABE,  32'hDEAD_BEEF,  32'hCAFE_BABE};

    // clock/reset
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op = MDU_MULT; bus.src_a = '0; bus.src_b = '0;
    bus.ex_adv = 1'b1; bus.flush = 1'b0; bus.div_ready_i = 1'b0; bus.div_result_i = '0;
    tick();
    @(negedge clk);
    chk("rst state", dbg_state, ST_IDLE);
    chk("rst stall", bus.stallreq_o, 1'b0);
    chk("rst hi", bus.hi_o, 32'd0);
    chk("rst lo", bus.lo_o, 32'd0);
    chk("rst div_start", bus.div_start_o, 1'b0);
    rst = 1'b0;
    tick();

    // MT/MF table
    for (int i = 0; i < 12; i++) begin
      bus.op_valid = vecs[i].op_valid;
      bus.op       = vecs[i].op;
      bus.src_a    = vecs[i].src_a;
      bus.flush    = vecs[i].flush;
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), bus.stallreq_o, vecs[i].exp_stall);
      chk($sformatf("vec%0d mf", i), bus.mf_data_o, vecs[i].exp_mf);
      chk($sformatf("vec%0d hi", i), bus.hi_o, vecs[i].exp_hi);
      chk($sformatf("vec%0d lo", i), bus.lo_o, vecs[i].exp_lo);
      tick();
    end
    bus.flush = 1'b0;

    // MULT -3 * 7
    bus.op_valid = 1'b1; bus.op = MDU_MULT; bus.src_a = 32'hFFFF_FFFD; bus.src_b = 32'd7; bus.ex_adv = 1'b0;
    @(negedge clk);
    chk("mul issue stall", bus.stallreq_o, 1'b1);
    chk("mul issue signed", bus.mul_signed_o, 1'b1);
    chk("mul issue ina", bus.mul_ina_o, 32'hFFFF_FFFD);
    chk("mul issue inb", bus.mul_inb_o, 32'd7);
    tick();
    bus.src_a = '0; bus.src_b = '0;
    @(negedge clk);
    chk("mul w1 stall", bus.stallreq_o, 1'b1);
    chk("mul w1 state", dbg_state, ST_MUL_WAIT);
    chk("mul w1 ina held", bus.mul_ina_o, 32'hFFFF_FFFD);
    chk("mul w1 inb held", bus.mul_inb_o, 32'd7);
    tick();
    @(negedge clk);
    chk("mul w2 stall", bus.stallreq_o, 1'b1);
    chk("mul w2 state", dbg_state, ST_MUL_WAIT);
    tick();
    @(negedge clk);
    chk("mul done stall", bus.stallreq_o, 1'b0);
    chk("mul done state", dbg_state, ST_DONE);
    chk("mul hi", bus.hi_o, 32'hFFFF_FFFF);
    chk("mul lo", bus.lo_o, 32'hFFFF_FFEB);
    bus.src_a = 32'hFFFF_FFFD; bus.src_b = 32'd7;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("done hold%0d stall", k), bus.stallreq_o, 1'b0);
      chk($sformatf("done hold%0d state", k), dbg_state, ST_DONE);
      chk($sformatf("done hold%0d ina", k), bus.mul_ina_o, 32'd0);
    end
    bus.ex_adv = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk("mul adv state", dbg_state, ST_IDLE);
    chk("mul adv hi", bus.hi_o, 32'hFFFF_FFFF);
    tick();

    // DIVU 100 / 7, ready 33 cycles after issue
    bus.op_valid = 1'b1; bus.op = MDU_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.ex_adv = 1'b0;
    @(negedge clk);
    chk("divu issue start", bus.div_start_o, 1'b1);
    chk("divu issue signed", bus.div_signed_o, 1'b0);
    chk("divu issue op1", bus.div_op1_o, 32'd100);
    chk("divu issue op2", bus.div_op2_o, 32'd7);
    chk("divu issue stall", bus.stallreq_o, 1'b1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("divu w%0d stall", k), bus.stallreq_o, 1'b1);
      chk($sformatf("divu w%0d start", k), bus.div_start_o, 1'b1);
    end
    tick();
    bus.div_ready_i = 1'b1; bus.div_result_i = {32'd2, 32'd14};
    @(negedge clk);
    chk("divu ready stall", bus.stallreq_o, 1'b0);
    chk("divu ready start", bus.div_start_o, 1'b0);
    tick();
    bus.div_ready_i = 1'b0; bus.div_result_i = '0;
    @(negedge clk);
    chk("divu done state", dbg_state, ST_DONE);
    chk("divu hi", bus.hi_o, 32'd2);
    chk("divu lo", bus.lo_o, 32'd14);
    bus.ex_adv = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk("divu adv state", dbg_state, ST_IDLE);
    tick();

    // DIV 5 / 0
    bus.op_valid = 1'b1; bus.op = MDU_DIV; bus.src_a = 32'd5; bus.src_b = 32'd0; bus.ex_adv = 1'b0;
    @(negedge clk);
    chk("div0 issue stall", bus.stallreq_o, 1'b1);
    chk("div0 issue start", bus.div_start_o, 1'b0);
    tick();
    @(negedge clk);
    chk("div0 done start", bus.div_start_o, 1'b0);
    chk("div0 done stall", bus.stallreq_o, 1'b0);
    chk("div0 done state", dbg_state, ST_DONE);
    chk("div0 hi", bus.hi_o, 32'd5);
    chk("div0 lo", bus.lo_o, 32'hFFFF_FFFF);
    bus.ex_adv = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    @(negedge clk);
    chk("div0 adv state", dbg_state, ST_IDLE);
    tick();

    // flush in DIV_WAIT at cycle 10, coinciding with ready
    bus.op_valid = 1'b1; bus.op = MDU_DIV; bus.src_a = 32'hFFFF_FF9C; bus.src_b = 32'd7; bus.ex_adv = 1'b0;
    @(negedge clk);
    chk("flush issue signed", bus.div_signed_o, 1'b1);
    chk("flush issue start", bus.div_start_o, 1'b1);
    for (int k = 1; k < 10; k++) tick();
    @(negedge clk);
    chk("flush w9 state", dbg_state, ST_DIV_WAIT);
    tick();
    bus.flush = 1'b1; bus.div_ready_i = 1'b1; bus.div_result_i = {32'd1, 32'd2};
    @(negedge clk);
    chk("flush annul", bus.div_annul_o, 1'b1);
    chk("flush stall", bus.stallreq_o, 1'b0);
    chk("flush start", bus.div_start_o, 1'b0);
    tick();
    bus.flush = 1'b0; bus.div_ready_i = 1'b0; bus.div_result_i = '0; bus.op_valid = 1'b0;
    @(negedge clk);
    chk("flush state", dbg_state, ST_IDLE);
    chk("flush annul off", bus.div_annul_o, 1'b0);
    chk("flush hi kept", bus.hi_o, 32'd5);
    chk("flush lo kept", bus.lo_o, 32'hFFFF_FFFF);
    tick();

    // async reset in the middle of MUL_WAIT
    bus.op_valid = 1'b1; bus.op = MDU_MULTU; bus.src_a = 32'd3; bus.src_b = 32'd4;
    @(negedge clk);
    chk("rmul issue stall", bus.stallreq_o, 1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async state", dbg_state, ST_IDLE);
    chk("async stall", bus.stallreq_o, 1'b0);
    chk("async ina", bus.mul_ina_o, 32'd0);
    chk("async hi", bus.hi_o, 32'd0);
    chk("async lo", bus.lo_o, 32'd0);
    tick();
    rst = 1'b0; bus.op_valid = 1'b0;
    @(negedge clk);
    chk("post rst state", dbg_state, ST_IDLE);
    chk("post rst stall", bus.stallreq_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
